// File: rtl/alu_rs_pkg.sv
// Shared widths, reset constants and entry layout for the ALU reservation station.
package alu_rs_pkg;

    localparam int RSsize  = 8;
    localparam int OpBus   = 6;
    localparam int TagBus  = 4;
    localparam int DataBus = 32;
    localparam int NameBus = 5;

    localparam logic [OpBus-1:0]   opFree   = '0;
    localparam logic [TagBus-1:0]  tagFree  = '0;
    localparam logic [DataBus-1:0] dataFree = '0;
    localparam logic [NameBus-1:0] nameFree = '0;

    typedef struct packed {
        logic [OpBus-1:0]   op;
        logic [TagBus-1:0]  tag1;
        logic [DataBus-1:0] data1;
        logic [TagBus-1:0]  tag2;
        logic [DataBus-1:0] data2;
        logic [TagBus-1:0]  dest_tag;
        logic [NameBus-1:0] name;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_lowbit_select.sv
// Lowest-set-bit picker: one-hot of the lowest set bit, its binary index and an any-set flag.
// Purely combinational, no backpressure.
module lowbit_select #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    assign onehot_o = x_i & (-x_i);
    assign any_o    = |x_i;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot_o[i]) idx_o = idx_o | IDX_W'(i);
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch into lowest free entry, CDB wakeup, issue of lowest-index ready entry.
// Issue is registered (one cycle residency); rsFull is combinational. RS_WAKEUP_BYPASS_EN issues on the live CDB match.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RSsize
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inEn,
    input  logic [OpBus-1:0]   inOp,
    input  logic [TagBus-1:0]  inTag1,
    input  logic [TagBus-1:0]  inTag2,
    input  logic [DataBus-1:0] inData1,
    input  logic [DataBus-1:0] inData2,
    input  logic [TagBus-1:0]  inDestTag,
    input  logic [NameBus-1:0] inName,
    input  logic               enCDBWrt,
    input  logic [TagBus-1:0]  CDBwrtTag,
    input  logic [DataBus-1:0] CDBwrtData,
    output logic               aluEn,
    output logic [OpBus-1:0]   aluOp,
    output logic [DataBus-1:0] aluData1,
    output logic [DataBus-1:0] aluData2,
    output logic [TagBus-1:0]  aluTag,
    output logic [NameBus-1:0] aluName,
    output logic               rsFull
);

    localparam int IW = $clog2(RS_SIZE);

    rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;
    logic [RS_SIZE-1:0]      valid_q, valid_d;
    logic [RS_SIZE-1:0]      wk1, wk2, ready;
    logic [RS_SIZE-1:0]      free_oh, issue_oh;
    logic [IW-1:0]           free_idx, issue_idx;
    logic                    free_any, issue_any;
    logic                    dispatch;
    rs_entry_t               new_ent, iss_ent;

    logic               alu_en_q;
    logic [OpBus-1:0]   alu_op_q;
    logic [DataBus-1:0] alu_data1_q, alu_data1_d;
    logic [DataBus-1:0] alu_data2_q, alu_data2_d;
    logic [TagBus-1:0]  alu_tag_q;
    logic [NameBus-1:0] alu_name_q;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            wk1[i] = enCDBWrt && (ent_q[i].tag1 != tagFree) && (ent_q[i].tag1 == CDBwrtTag);
            wk2[i] = enCDBWrt && (ent_q[i].tag2 != tagFree) && (ent_q[i].tag2 == CDBwrtTag);
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i] = valid_q[i] && ((ent_q[i].tag1 == tagFree) || wk1[i])
                                  && ((ent_q[i].tag2 == tagFree) || wk2[i]);
`else
            ready[i] = valid_q[i] && (ent_q[i].tag1 == tagFree) && (ent_q[i].tag2 == tagFree);
`endif
        end
    end

    lowbit_select #(.WIDTH(RS_SIZE), .IDX_W(IW)) u_free_sel (
        .x_i      (~valid_q),
        .onehot_o (free_oh),
        .idx_o    (free_idx),
        .any_o    (free_any)
    );

    lowbit_select #(.WIDTH(RS_SIZE), .IDX_W(IW)) u_issue_sel (
        .x_i      (ready),
        .onehot_o (issue_oh),
        .idx_o    (issue_idx),
        .any_o    (issue_any)
    );

    assign rsFull   = &valid_q;
    assign dispatch = inEn && !rsFull;

    // Incoming operands can be satisfied by a broadcast in the very dispatch cycle.
    always_comb begin
        new_ent          = '0;
        new_ent.op       = inOp;
        new_ent.tag1     = inTag1;
        new_ent.data1    = inData1;
        new_ent.tag2     = inTag2;
        new_ent.data2    = inData2;
        new_ent.dest_tag = inDestTag;
        new_ent.name     = inName;
        if (enCDBWrt && (inTag1 != tagFree) && (inTag1 == CDBwrtTag)) begin
            new_ent.tag1  = tagFree;
            new_ent.data1 = CDBwrtData;
        end
        if (enCDBWrt && (inTag2 != tagFree) && (inTag2 == CDBwrtTag)) begin
            new_ent.tag2  = tagFree;
            new_ent.data2 = CDBwrtData;
        end
    end

    always_comb begin
        ent_d   = ent_q;
        valid_d = valid_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (wk1[i]) begin
                ent_d[i].tag1  = tagFree;
                ent_d[i].data1 = CDBwrtData;
            end
            if (wk2[i]) begin
                ent_d[i].tag2  = tagFree;
                ent_d[i].data2 = CDBwrtData;
            end
        end
        if (issue_any) valid_d[issue_idx] = 1'b0;
        // The free pick only sees entries invalid now, so it never collides with the issuing one.
        if (dispatch && free_any) begin
            valid_d[free_idx] = 1'b1;
            ent_d[free_idx]   = new_ent;
        end
    end

    always_comb begin
        iss_ent     = ent_q[issue_idx];
        alu_data1_d = iss_ent.data1;
        alu_data2_d = iss_ent.data2;
`ifdef RS_WAKEUP_BYPASS_EN
        if (wk1[issue_idx]) alu_data1_d = CDBwrtData;
        if (wk2[issue_idx]) alu_data2_d = CDBwrtData;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q     <= '0;
            ent_q       <= '0;
            alu_en_q    <= 1'b0;
            alu_op_q    <= opFree;
            alu_data1_q <= dataFree;
            alu_data2_q <= dataFree;
            alu_tag_q   <= tagFree;
            alu_name_q  <= nameFree;
        end else begin
            valid_q  <= valid_d;
            ent_q    <= ent_d;
            alu_en_q <= issue_any;
            if (issue_any) begin
                alu_op_q    <= iss_ent.op;
                alu_data1_q <= alu_data1_d;
                alu_data2_q <= alu_data2_d;
                alu_tag_q   <= iss_ent.dest_tag;
                alu_name_q  <= iss_ent.name;
            end
        end
    end

    assign aluEn    = alu_en_q;
    assign aluOp    = alu_op_q;
    assign aluData1 = alu_data1_q;
    assign aluData2 = alu_data2_q;
    assign aluTag   = alu_tag_q;
    assign aluName  = alu_name_q;

endmodule
